// File: rtl/aqp_esp_tx_arbiter.sv
// Round-robin, frame-atomic arbiter that merges NUM_REQ byte streams into the ESP UART TX FIFO.
// Optional trailing checksum byte per frame is enabled by defining AQP_ESP_TX_CHKSUM_EN.
module aqp_esp_tx_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter logic [7:0]  CH_BASE = 8'h00,
  localparam int         IDXW    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [8:0]             txfifo_data,
  output logic                   txfifo_wr,
  input  logic                   txfifo_full,
  output logic                   busy,
  output logic [IDXW-1:0]        grant_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_CHAN,
`ifdef AQP_ESP_TX_CHKSUM_EN
    S_DATA,
    S_CHK
`else
    S_DATA
`endif
  } state_t;

  state_t                    state;
  logic [NUM_REQ-1:0][7:0]   req_bytes;
  logic [7:0]                chan_byte;
  logic [7:0]                cur_byte;
  logic                      cur_valid;
  logic                      cur_last;
  logic                      xfer;
  logic [IDXW-1:0]           next_grant;
  logic [IDXW-1:0]           cand;
`ifdef AQP_ESP_TX_CHKSUM_EN
  logic [7:0]                chk;
`endif

  assign req_bytes = req_data;
  assign chan_byte = CH_BASE + 8'(grant_idx);
  assign cur_byte  = req_bytes[grant_idx];
  assign cur_valid = req_valid[grant_idx];
  assign cur_last  = req_last[grant_idx];
  assign xfer      = (state == S_DATA) && cur_valid && !txfifo_full;
  assign busy      = (state != S_IDLE);

  // Scan from the farthest candidate back to the nearest so the last hit is the first valid after grant_idx.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    next_grant = grant_idx;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDXW'((int'(grant_idx) + k) % NUM_REQ);
      if (req_valid[cand]) next_grant = cand;
    end
  end

  always_comb begin
    txfifo_wr   = 1'b0;
    txfifo_data = 9'h000;
    req_ready   = '0;
    case (state)
      S_SOF: begin
        txfifo_data = 9'h100;
        txfifo_wr   = !txfifo_full;
      end
      S_CHAN: begin
        txfifo_data = {1'b0, chan_byte};
        txfifo_wr   = !txfifo_full;
      end
      S_DATA: begin
        txfifo_data          = {1'b0, cur_byte};
        txfifo_wr            = cur_valid && !txfifo_full;
        req_ready[grant_idx] = !txfifo_full;
      end
`ifdef AQP_ESP_TX_CHKSUM_EN
      S_CHK: begin
        txfifo_data = {1'b0, chk};
        txfifo_wr   = !txfifo_full;
      end
`endif
      default: ;
    endcase
  end

  // The grant is registered in IDLE, so the first FIFO write (SOF) lands one cycle after the request is seen.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state     <= S_IDLE;
      grant_idx <= IDXW'(NUM_REQ - 1);
`ifdef AQP_ESP_TX_CHKSUM_EN
      chk       <= 8'h00;
`endif
    end else begin
      case (state)
        S_IDLE: if (|req_valid) begin
          grant_idx <= next_grant;
          state     <= S_SOF;
`ifdef AQP_ESP_TX_CHKSUM_EN
          chk       <= 8'h00;
`endif
        end
        S_SOF:  if (!txfifo_full) state <= S_CHAN;
        S_CHAN: if (!txfifo_full) begin
          state <= S_DATA;
`ifdef AQP_ESP_TX_CHKSUM_EN
          chk   <= chk + chan_byte;
`endif
        end
        S_DATA: if (xfer) begin
`ifdef AQP_ESP_TX_CHKSUM_EN
          chk <= chk + cur_byte;
          if (cur_last) state <= S_CHK;
`else
          if (cur_last) state <= S_IDLE;
`endif
        end
`ifdef AQP_ESP_TX_CHKSUM_EN
        S_CHK:  if (!txfifo_full) state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
